register_write_arbiter: RTL and testbench



---
 rtl/register_arbiter_pkg.sv | 23 ++
 rtl/rr_priority_picker.sv | 34 +++
 rtl/register_write_arbiter.sv | 140 ++++++++++++++
 tb/tb_register_write_arbiter.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/register_arbiter_pkg.sv
// Shared definitions for the round-robin register write arbiter:
// FSM encoding, default sizes and a one-hot helper.
package register_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        WRITE = 2'd2
    } arb_state_e;

    localparam int DEFAULT_WIDTH   = 32;
    localparam int DEFAULT_NUM_REQ = 4;
    localparam int MAX_REQ         = 8;
    localparam int IDX_W           = 3;

    function automatic logic [MAX_REQ-1:0] onehot(input logic [IDX_W-1:0] index);
        logic [MAX_REQ-1:0] vec;
        vec        = {MAX_REQ{1'b0}};
        vec[index] = 1'b1;
        return vec;
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first set request scanning ptr, ptr+1, ...
// with wrap-around. Reusable wherever a rotating-priority choice is needed.
module rr_priority_picker #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [PTR_W-1:0]   winner,
    output logic               valid
);

    logic [PTR_W-1:0] lo_idx_s;
    logic [PTR_W-1:0] hi_idx_s;
    logic             hi_found_s;
    logic             take_hi_s;

    // Descending scan so the lowest index at/after ptr (or overall, on wrap) wins.
    always_comb begin
        lo_idx_s   = {PTR_W{1'b0}};
        hi_idx_s   = {PTR_W{1'b0}};
        hi_found_s = 1'b0;
        take_hi_s  = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            take_hi_s  = req[i] && (PTR_W'(i) >= ptr);
            lo_idx_s   = req[i] ? PTR_W'(i) : lo_idx_s;
            hi_idx_s   = take_hi_s ? PTR_W'(i) : hi_idx_s;
            hi_found_s = hi_found_s | take_hi_s;
        end
        winner = hi_found_s ? hi_idx_s : lo_idx_s;
        valid  = |req;
    end

endmodule

// File: rtl/register_write_arbiter.sv
// Round-robin arbiter granting NUM_REQ requesters one-at-a-time access to a
// shared clock-enabled register; every output is registered.
module register_write_arbiter
    import register_arbiter_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int NUM_REQ = DEFAULT_NUM_REQ
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     clock_enable,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]       grant,
    output logic [NUM_REQ-1:0]       ack,
    output logic [WIDTH-1:0]         reg_input_signal,
    output logic                     reg_clock_enable,
    output logic                     busy
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_e         state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [PTR_W-1:0]   winner_q, winner_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic               ce_q, ce_d;
    logic               busy_q, busy_d;

    logic [PTR_W-1:0]   next_ptr_s;
    logic [PTR_W-1:0]   pick_ptr_s;
    logic [PTR_W-1:0]   pick_idx_s;
    logic               pick_valid_s;
    logic [NUM_REQ-1:0] pick_onehot_s;
    logic [NUM_REQ-1:0] cur_onehot_s;
    logic [WIDTH-1:0]   req_data_s [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign req_data_s[g] = req_data[g*WIDTH +: WIDTH];
    end

    // In WRITE the pointer already advances past the current winner, so a
    // back-to-back arbitration sees the rotated priority immediately.
    assign next_ptr_s    = (winner_q == PTR_W'(NUM_REQ - 1)) ? {PTR_W{1'b0}} : winner_q + PTR_W'(1);
    assign pick_ptr_s    = (state_q == WRITE) ? next_ptr_s : ptr_q;
    assign pick_onehot_s = NUM_REQ'(onehot(IDX_W'(pick_idx_s)));
    assign cur_onehot_s  = NUM_REQ'(onehot(IDX_W'(winner_q)));

    rr_priority_picker #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_picker (
        .req    (req),
        .ptr    (pick_ptr_s),
        .winner (pick_idx_s),
        .valid  (pick_valid_s)
    );

    // Next-state and next-output logic for the IDLE/GRANT/WRITE sequence.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        winner_d = winner_q;
        grant_d  = grant_q;
        data_d   = data_q;
        busy_d   = busy_q;
        ack_d    = {NUM_REQ{1'b0}};
        ce_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (clock_enable && pick_valid_s) begin
                    state_d  = GRANT;
                    winner_d = pick_idx_s;
                    grant_d  = pick_onehot_s;
                    busy_d   = 1'b1;
                end else begin
                    grant_d = {NUM_REQ{1'b0}};
                    busy_d  = 1'b0;
                end
            end
            GRANT: begin
                // Proceeds regardless of clock_enable or a dropped req.
                state_d = WRITE;
                data_d  = req_data_s[winner_q];
                ce_d    = 1'b1;
                ack_d   = cur_onehot_s;
            end
            WRITE: begin
                ptr_d = next_ptr_s;
                if (clock_enable && pick_valid_s) begin
                    state_d  = GRANT;
                    winner_d = pick_idx_s;
                    grant_d  = pick_onehot_s;
                    busy_d   = 1'b1;
                end else begin
                    state_d = IDLE;
                    grant_d = {NUM_REQ{1'b0}};
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = {NUM_REQ{1'b0}};
                busy_d  = 1'b0;
            end
        endcase
    end

    // State, pointer and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            ptr_q    <= {PTR_W{1'b0}};
            winner_q <= {PTR_W{1'b0}};
            grant_q  <= {NUM_REQ{1'b0}};
            ack_q    <= {NUM_REQ{1'b0}};
            data_q   <= {WIDTH{1'b0}};
            ce_q     <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            winner_q <= winner_d;
            grant_q  <= grant_d;
            ack_q    <= ack_d;
            data_q   <= data_d;
            ce_q     <= ce_d;
            busy_q   <= busy_d;
        end
    end

    assign grant            = grant_q;
    assign ack              = ack_q;
    assign reg_input_signal = data_q;
    assign reg_clock_enable = ce_q;
    assign busy             = busy_q;

endmodule

// File: tb/tb_register_write_arbiter.sv
// Directed bench for register_write_arbiter with a model of the shared register.
module tb_register_write_arbiter;

    logic         clock = 1'b0;
    logic         reset;
    logic         clock_enable;
    logic [3:0]   req;
    logic [127:0] req_data;
    logic [3:0]   grant;
    logic [3:0]   ack;
    logic [31:0]  reg_input_signal;
    logic         reg_clock_enable;
    logic         busy;

    logic [31:0]  shared_q = 32'h0;
    logic [31:0]  dvec [4];
    logic         started = 1'b0;
    int           checks = 0;
    int           failures = 0;

    register_write_arbiter #(.WIDTH(32), .NUM_REQ(4)) dut (
        .clock            (clock),
        .reset            (reset),
        .clock_enable     (clock_enable),
        .req              (req),
        .req_data         (req_data),
        .grant            (grant),
        .ack              (ack),
        .reg_input_signal (reg_input_signal),
        .reg_clock_enable (reg_clock_enable),
        .busy             (busy)
    );

    always #5 clock = ~clock;

    // The shared storage element the arbiter drives.
    always @(posedge clock) begin
        if (reg_clock_enable) shared_q <= reg_input_signal;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic load_data();
        req_data = {dvec[3], dvec[2], dvec[1], dvec[0]};
    endtask

    // Invariants checked every cycle once out of the initial reset.
    always @(negedge clock) begin
        if (started && !reset) begin
            chk("onehot_grant", 64'($onehot0(grant)), 64'd1);
            chk("onehot_ack", 64'($onehot0(ack)), 64'd1);
            chk("grant_busy", 64'(|grant), 64'(busy));
        end
    end

    initial begin
        reset        = 1'b1;
        clock_enable = 1'b0;
        req          = 4'b0000;
        dvec[0]      = 32'h1111_0000;
        dvec[1]      = 32'h2222_0001;
        dvec[2]      = 32'h0000_03FF;
        dvec[3]      = 32'h4444_0003;
        load_data();
        step();
        step();
        reset   = 1'b0;
        started = 1'b1;

        // Idle after reset
        clock_enable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("idle_busy", 64'(busy), 64'd0);
            chk("idle_grant", 64'(grant), 64'd0);
            chk("idle_ce", 64'(reg_clock_enable), 64'd0);
            chk("idle_data", 64'(reg_input_signal), 64'd0);
        end

        // Single write from requester 2
        req = 4'b0100;
        step();
        chk("single_grant", 64'(grant), 64'h4);
        chk("single_ce_low", 64'(reg_clock_enable), 64'd0);
        step();
        chk("single_ce", 64'(reg_clock_enable), 64'd1);
        chk("single_ack", 64'(ack), 64'h4);
        chk("single_data", 64'(reg_input_signal), 64'h3FF);
        req = 4'b0000;
        step();
        chk("single_ce_off", 64'(reg_clock_enable), 64'd0);
        chk("single_ack_off", 64'(ack), 64'd0);
        chk("single_shared", 64'(shared_q), 64'h3FF);
        chk("single_busy_off", 64'(busy), 64'd0);

        // Pointer is 3: of requesters 0 and 3, requester 3 wins
        req = 4'b1001;
        step();
        chk("ptr3_grant", 64'(grant), 64'h8);
        step();
        chk("ptr3_ack", 64'(ack), 64'h8);
        chk("ptr3_data", 64'(reg_input_signal), 64'h4444_0003);
        req = 4'b0000;
        step();
        chk("ptr3_shared", 64'(shared_q), 64'h4444_0003);

        // Back-to-back round robin from pointer 0
        dvec[2] = 32'h3333_0002;
        load_data();
        req = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("rr_grant", 64'(grant), 64'(4'b0001 << k));
            chk("rr_ack_gap", 64'(ack), 64'd0);
            if (k > 0) chk("rr_shared", 64'(shared_q), 64'(dvec[k-1]));
            step();
            chk("rr_ack", 64'(ack), 64'(4'b0001 << k));
            chk("rr_data", 64'(reg_input_signal), 64'(dvec[k]));
            chk("rr_ce", 64'(reg_clock_enable), 64'd1);
        end

        // clock_enable dropped in GRANT
        step();
        chk("ce_wrap_grant", 64'(grant), 64'h1);
        chk("ce_wrap_shared", 64'(shared_q), 64'h4444_0003);
        clock_enable = 1'b0;
        step();
        chk("ce_ack", 64'(ack), 64'h1);
        chk("ce_data", 64'(reg_input_signal), 64'h1111_0000);
        step();
        chk("ce_idle_grant", 64'(grant), 64'd0);
        chk("ce_idle_busy", 64'(busy), 64'd0);
        chk("ce_shared", 64'(shared_q), 64'h1111_0000);
        step();
        step();
        chk("ce_hold_grant", 64'(grant), 64'd0);
        clock_enable = 1'b1;
        step();
        chk("ce_resume_grant", 64'(grant), 64'h2);
        step();
        chk("ce_resume_ack", 64'(ack), 64'h2);
        chk("ce_resume_data", 64'(reg_input_signal), 64'h2222_0001);
        req = 4'b0000;
        step();
        chk("ce_resume_shared", 64'(shared_q), 64'h2222_0001);

        // Reset during GRANT
        req = 4'b0100;
        step();
        chk("rst_pre_grant", 64'(grant), 64'h4);
        reset = 1'b1;
        step();
        chk("rst_ack", 64'(ack), 64'd0);
        chk("rst_ce", 64'(reg_clock_enable), 64'd0);
        chk("rst_grant", 64'(grant), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_data", 64'(reg_input_signal), 64'd0);
        reset = 1'b0;
        req   = 4'b1000;
        step();
        chk("rst_shared", 64'(shared_q), 64'h2222_0001);
        chk("rst_next_grant", 64'(grant), 64'h8);
        step();
        chk("rst_next_ack", 64'(ack), 64'h8);
        req = 4'b0000;
        step();
        chk("rst_next_shared", 64'(shared_q), 64'h4444_0003);

        // Requester 1 drops req during GRANT
        dvec[1] = 32'hCAFE_0001;
        load_data();
        req = 4'b0010;
        step();
        chk("drop_grant", 64'(grant), 64'h2);
        req = 4'b0000;
        step();
        chk("drop_ack", 64'(ack), 64'h2);
        chk("drop_ce", 64'(reg_clock_enable), 64'd1);
        chk("drop_data", 64'(reg_input_signal), 64'hCAFE_0001);
        step();
        chk("drop_shared", 64'(shared_q), 64'hCAFE_0001);
        chk("drop_idle", 64'(busy), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
